imuldiv_int_mul_div_iterative: RTL and testbench



---
 rtl/imuldiv_int_mul_div_iterative_pkg.sv | 25 ++
 rtl/imuldiv_int_mul_div_iterative_if.sv | 42 ++++
 rtl/imuldiv_muldiv_iter_dpath.sv | 163 ++++++++++++++++
 rtl/imuldiv_int_mul_div_iterative.sv | 91 +++++++++
 tb/tb_imuldiv_int_mul_div_iterative.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imuldiv_int_mul_div_iterative_pkg.sv
// ---------------------------------------------------------------------------
// imuldiv_int_mul_div_iterative_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// codes, the control FSM state encoding and the iteration count.
// ---------------------------------------------------------------------------
package imuldiv_int_mul_div_iterative_pkg;

    // Operation codes carried on muldivreq_msg_fn; codes 5..7 execute as MUL
    localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_MUL  = 3'd0;
    localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_DIV  = 3'd1;
    localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_DIVU = 3'd2;
    localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_REM  = 3'd3;
    localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_REMU = 3'd4;

    // One shift-add or shift-subtract step per operand bit
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/imuldiv_int_mul_div_iterative_if.sv
// ---------------------------------------------------------------------------
// imuldiv_int_mul_div_iterative_if
// Request/response bundle of the multiply/divide unit.
//   request : muldivreq_msg_fn[3], muldivreq_msg_a[32], muldivreq_msg_b[32],
//             muldivreq_val, muldivreq_rdy
//   response: muldivresp_msg_result[64], muldivresp_val, muldivresp_rdy
// master = requester/consumer side, slave = the unit itself.
// ---------------------------------------------------------------------------
interface imuldiv_int_mul_div_iterative_if;

    logic [2:0]  muldivreq_msg_fn;
    logic [31:0] muldivreq_msg_a;
    logic [31:0] muldivreq_msg_b;
    logic        muldivreq_val;
    logic        muldivreq_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val;
    logic        muldivresp_rdy;

    modport master (
        output muldivreq_msg_fn,
        output muldivreq_msg_a,
        output muldivreq_msg_b,
        output muldivreq_val,
        input  muldivreq_rdy,
        input  muldivresp_msg_result,
        input  muldivresp_val,
        output muldivresp_rdy
    );

    modport slave (
        input  muldivreq_msg_fn,
        input  muldivreq_msg_a,
        input  muldivreq_msg_b,
        input  muldivreq_val,
        output muldivreq_rdy,
        output muldivresp_msg_result,
        output muldivresp_val,
        input  muldivresp_rdy
    );

endinterface

// File: rtl/imuldiv_muldiv_iter_dpath.sv
// ---------------------------------------------------------------------------
// imuldiv_muldiv_iter_dpath
// Datapath of the iterative multiply/divide unit. Operates on magnitudes
// and applies sign correction when the final step is written.
//   clk, reset : clock, asynchronous active-low reset
//   start_i    : latch fn and operands (request accepted)
//   step_i     : perform one iteration step
//   last_i     : this step is the final one; capture the packed result
//   fn_i       : operation code
//   a_i, b_i   : operands
//   result_o   : registered 64-bit result
// ---------------------------------------------------------------------------
module imuldiv_muldiv_iter_dpath
    import imuldiv_int_mul_div_iterative_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        step_i,
    input  logic        last_i,
    input  logic [2:0]  fn_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] result_o
);

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    // Quotient is never negated on divide by zero so it stays all-ones;
    // the remainder then holds |A| and re-signing restores A exactly.
    function automatic logic [63:0] pack_result(
        input logic [63:0] acc,
        input logic        is_mul,
        input logic        neg,
        input logic        sign_a,
        input logic        b_zero
    );
        logic [31:0] q;
        logic [31:0] r;
        q = acc[31:0];
        r = acc[63:32];
        if (is_mul) begin
            return neg ? neg64(acc) : acc;
        end
        if (neg && !b_zero) q = neg32(q);
        if (sign_a)         r = neg32(r);
        return {r, q};
    endfunction

    logic        is_mul_q,  is_mul_d;
    logic        neg_q,     neg_d;
    logic        sign_a_q,  sign_a_d;
    logic        b_zero_q,  b_zero_d;
    logic [63:0] opa_q,     opa_d;
    logic [31:0] opb_q,     opb_d;
    logic [63:0] acc_q,     acc_d;
    logic [63:0] result_q,  result_d;

    logic        signed_op;
    logic        is_mul_op;
    logic        sign_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [64:0] add_a;
    logic [64:0] add_b;
    logic        add_cin;
    logic [64:0] add_sum;
    logic [63:0] acc_step;
    logic [63:0] opa_step;
    logic [31:0] opb_step;

    // Operand decode and magnitude capture at accept
    always_comb begin
        signed_op = !(fn_i == IMULDIV_MULDIVREQ_MSG_FUNC_DIVU ||
                      fn_i == IMULDIV_MULDIVREQ_MSG_FUNC_REMU);
        is_mul_op = !(fn_i == IMULDIV_MULDIVREQ_MSG_FUNC_DIV  ||
                      fn_i == IMULDIV_MULDIVREQ_MSG_FUNC_DIVU ||
                      fn_i == IMULDIV_MULDIVREQ_MSG_FUNC_REM  ||
                      fn_i == IMULDIV_MULDIVREQ_MSG_FUNC_REMU);
        sign_b    = signed_op && b_i[31];
        abs_a     = (signed_op && a_i[31]) ? neg32(a_i) : a_i;
        abs_b     = sign_b ? neg32(b_i) : b_i;
    end

    // Shared 65-bit adder. MUL: acc + shifted multiplicand. DIV: the
    // left-shifted {rem,quot} minus {divisor,32'b0}; bit 64 of the wrapped
    // sum is the borrow, i.e. set when the trial subtraction goes negative.
    always_comb begin
        add_a   = is_mul_q ? {1'b0, acc_q} : {acc_q, 1'b0};
        add_b   = is_mul_q ? {1'b0, opa_q} : {~{1'b0, opb_q}, 32'hFFFF_FFFF};
        add_cin = !is_mul_q;
        add_sum = add_a + add_b + {64'd0, add_cin};

        if (is_mul_q) begin
            acc_step = opb_q[0] ? add_sum[63:0] : acc_q;
            opa_step = {opa_q[62:0], 1'b0};
            opb_step = {1'b0, opb_q[31:1]};
        end else begin
            acc_step = add_sum[64] ? add_a[63:0]
                                   : {add_sum[63:32], add_a[31:1], 1'b1};
            opa_step = opa_q;
            opb_step = opb_q;
        end
    end

    always_comb begin
        is_mul_d = is_mul_q;
        neg_d    = neg_q;
        sign_a_d = sign_a_q;
        b_zero_d = b_zero_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (start_i) begin
            is_mul_d = is_mul_op;
            sign_a_d = signed_op && a_i[31];
            neg_d    = (signed_op && a_i[31]) ^ sign_b;
            b_zero_d = (b_i == 32'd0);
            opa_d    = {32'd0, abs_a};
            opb_d    = abs_b;
            acc_d    = is_mul_op ? 64'd0 : {32'd0, abs_a};
        end else if (step_i) begin
            opa_d = opa_step;
            opb_d = opb_step;
            acc_d = acc_step;
            if (last_i) begin
                result_d = pack_result(acc_step, is_mul_q, neg_q, sign_a_q, b_zero_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_mul_q <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            b_zero_q <= 1'b0;
            opa_q    <= 64'd0;
            opb_q    <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 64'd0;
        end else begin
            is_mul_q <= is_mul_d;
            neg_q    <= neg_d;
            sign_a_q <= sign_a_d;
            b_zero_q <= b_zero_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/imuldiv_int_mul_div_iterative.sv
// ---------------------------------------------------------------------------
// imuldiv_int_mul_div_iterative
// Iterative 32-bit multiply/divide unit: one request at a time, fixed
// 32-step computation, 64-bit result returned over a val/rdy handshake.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : request/response bundle (slave side)
// Control (FSM, iteration counter, handshakes) lives here; arithmetic is in
// imuldiv_muldiv_iter_dpath.
// ---------------------------------------------------------------------------
module imuldiv_int_mul_div_iterative
    import imuldiv_int_mul_div_iterative_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    imuldiv_int_mul_div_iterative_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_COUNT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               start;
    logic               step;
    logic               last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.muldivreq_val) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Returning to IDLE rather than accepting here keeps one
                // idle cycle between a consume and the next accept.
                if (bus.muldivresp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    imuldiv_muldiv_iter_dpath u_dpath (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start),
        .step_i   (step),
        .last_i   (last),
        .fn_i     (bus.muldivreq_msg_fn),
        .a_i      (bus.muldivreq_msg_a),
        .b_i      (bus.muldivreq_msg_b),
        .result_o (bus.muldivresp_msg_result)
    );

    // Handshake outputs decode the state register only
    assign bus.muldivreq_rdy  = (state_q == ST_IDLE);
    assign bus.muldivresp_val = (state_q == ST_DONE);

endmodule

// File: tb/tb_imuldiv_int_mul_div_iterative.sv
module tb_imuldiv_int_mul_div_iterative;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    imuldiv_int_mul_div_iterative_if bus ();

    imuldiv_int_mul_div_iterative dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request (DUT assumed idle), scramble inputs after accept,
    // wait for the response and let it be consumed with resp_rdy high.
    task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat);
        bus.muldivresp_rdy   = 1'b1;
        bus.muldivreq_msg_fn = fn;
        bus.muldivreq_msg_a  = a;
        bus.muldivreq_msg_b  = b;
        bus.muldivreq_val    = 1'b1;
        @(posedge clk); #1;
        bus.muldivreq_val    = 1'b0;
        bus.muldivreq_msg_fn = 3'($urandom_range(0, 7));
        bus.muldivreq_msg_a  = $urandom;
        bus.muldivreq_msg_b  = $urandom;
        lat = 0;
        while (bus.muldivresp_val !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.muldivresp_msg_result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset                = 1'b0;
        bus.muldivreq_val    = 1'b0;
        bus.muldivreq_msg_fn = 3'd0;
        bus.muldivreq_msg_a  = 32'd0;
        bus.muldivreq_msg_b  = 32'd0;
        bus.muldivresp_rdy   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.muldivreq_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_req_rdy: got %b want 1", bus.muldivreq_rdy);
        end
        vectors++;
        if (bus.muldivresp_val !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_resp_val: got %b want 0", bus.muldivresp_val);
        end
        vectors++;
        if (bus.muldivresp_msg_result !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_result: got %h want 0", bus.muldivresp_msg_result);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul;
        logic [63:0] r;
        int          lat;
        run_op(3'd0, 32'd3, 32'hFFFF_FFFC, r, lat);
        vectors++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFF4) begin
            miscompares++;
            $display("FAIL mul_3x-4: got %h want fffffffffffffff4", r);
        end
        vectors++;
        if (lat !== 32) begin
            miscompares++;
            $display("FAIL mul_latency: got %0d want 32", lat);
        end
        run_op(3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, r, lat);
        vectors++;
        if (r !== 64'd6) begin
            miscompares++;
            $display("FAIL mul_-2x-3: got %h want 6", r);
        end
        run_op(3'd5, 32'd6, 32'd7, r, lat);
        vectors++;
        if (r !== 64'd42) begin
            miscompares++;
            $display("FAIL mul_fn5: got %h want 2a", r);
        end
    endtask

    task automatic test_div;
        logic [63:0] r;
        int          lat;
        run_op(3'd1, 32'hFFFF_FFF9, 32'd2, r, lat);
        vectors++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            miscompares++;
            $display("FAIL div_-7/2: got %h want fffffffffffffffd", r);
        end
        vectors++;
        if (lat !== 32) begin
            miscompares++;
            $display("FAIL div_latency: got %0d want 32", lat);
        end
        run_op(3'd3, 32'd7, 32'hFFFF_FFFE, r, lat);
        vectors++;
        if (r !== 64'h0000_0001_FFFF_FFFD) begin
            miscompares++;
            $display("FAIL rem_7/-2: got %h want 00000001fffffffd", r);
        end
    endtask

    task automatic test_unsigned;
        logic [63:0] r;
        int          lat;
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, r, lat);
        vectors++;
        if (r !== 64'h0000_0001_7FFF_FFFF) begin
            miscompares++;
            $display("FAIL divu_ffffffff/2: got %h want 000000017fffffff", r);
        end
        run_op(3'd4, 32'd100, 32'd7, r, lat);
        vectors++;
        if (r[63:32] !== 32'd2) begin
            miscompares++;
            $display("FAIL remu_100/7_rem: got %h want 2", r[63:32]);
        end
        vectors++;
        if (r[31:0] !== 32'd14) begin
            miscompares++;
            $display("FAIL remu_100/7_quot: got %h want e", r[31:0]);
        end
    endtask

    task automatic test_divzero;
        logic [63:0] r;
        int          lat;
        run_op(3'd1, 32'd5, 32'd0, r, lat);
        vectors++;
        if (r !== 64'h0000_0005_FFFF_FFFF) begin
            miscompares++;
            $display("FAIL div_5/0: got %h want 00000005ffffffff", r);
        end
        vectors++;
        if (lat !== 32) begin
            miscompares++;
            $display("FAIL div0_latency: got %0d want 32", lat);
        end
        run_op(3'd3, 32'hFFFF_FFF9, 32'd0, r, lat);
        vectors++;
        if (r !== 64'hFFFF_FFF9_FFFF_FFFF) begin
            miscompares++;
            $display("FAIL rem_-7/0: got %h want fffffff9ffffffff", r);
        end
        run_op(3'd2, 32'h8000_0001, 32'd0, r, lat);
        vectors++;
        if (r !== 64'h8000_0001_FFFF_FFFF) begin
            miscompares++;
            $display("FAIL divu_80000001/0: got %h want 80000001ffffffff", r);
        end
    endtask

    task automatic test_overflow;
        logic [63:0] r;
        int          lat;
        run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        vectors++;
        if (r !== 64'h0000_0000_8000_0000) begin
            miscompares++;
            $display("FAIL div_overflow: got %h want 0000000080000000", r);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] r;
        int          lat;
        bus.muldivresp_rdy   = 1'b0;
        bus.muldivreq_msg_fn = 3'd0;
        bus.muldivreq_msg_a  = 32'h7FFF_FFFF;
        bus.muldivreq_msg_b  = 32'h7FFF_FFFF;
        bus.muldivreq_val    = 1'b1;
        @(posedge clk); #1;
        // Keep a different request pending; it must be ignored
        bus.muldivreq_msg_a  = 32'd1;
        bus.muldivreq_msg_b  = 32'd1;
        lat = 0;
        while (bus.muldivresp_val !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat !== 32) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d want 32", lat);
        end
        r = bus.muldivresp_msg_result;
        vectors++;
        if (r !== 64'h3FFF_FFFF_0000_0001) begin
            miscompares++;
            $display("FAIL mul_max_pos: got %h want 3fffffff00000001", r);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.muldivresp_val !== 1'b1 || bus.muldivresp_msg_result !== 64'h3FFF_FFFF_0000_0001) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got val=%b res=%h want val=1 res=3fffffff00000001",
                         i, bus.muldivresp_val, bus.muldivresp_msg_result);
            end
            vectors++;
            if (bus.muldivreq_rdy !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_req_rdy[%0d]: got %b want 0", i, bus.muldivreq_rdy);
            end
        end
        bus.muldivreq_val  = 1'b0;
        bus.muldivresp_rdy = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.muldivresp_val !== 1'b0 || bus.muldivreq_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got resp_val=%b req_rdy=%b want 0/1",
                     bus.muldivresp_val, bus.muldivreq_rdy);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bus.muldivresp_rdy   = 1'b1;
        bus.muldivreq_msg_fn = 3'd4;
        bus.muldivreq_msg_a  = 32'd100;
        bus.muldivreq_msg_b  = 32'd7;
        bus.muldivreq_val    = 1'b1;
        @(posedge clk); #1;
        // Second request stays valid the whole time
        bus.muldivreq_msg_fn = 3'd1;
        bus.muldivreq_msg_a  = 32'hFFFF_FF9C;
        bus.muldivreq_msg_b  = 32'd7;
        lat = 0;
        while (bus.muldivresp_val !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (bus.muldivresp_msg_result !== 64'h0000_0002_0000_000E || lat !== 32) begin
            miscompares++;
            $display("FAIL b2b_first: got %h lat %0d want 000000020000000e lat 32",
                     bus.muldivresp_msg_result, lat);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.muldivreq_rdy !== 1'b1 || bus.muldivresp_val !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_accept_on_consume: got req_rdy=%b resp_val=%b want 1/0",
                     bus.muldivreq_rdy, bus.muldivresp_val);
        end
        @(posedge clk); #1;
        bus.muldivreq_val = 1'b0;
        vectors++;
        if (bus.muldivreq_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second_accept: got req_rdy=%b want 0", bus.muldivreq_rdy);
        end
        lat = 0;
        while (bus.muldivresp_val !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        // -100 / 7 = -14 rem -2
        vectors++;
        if (bus.muldivresp_msg_result !== 64'hFFFF_FFFE_FFFF_FFF2 || lat !== 32) begin
            miscompares++;
            $display("FAIL b2b_second: got %h lat %0d want fffffffefffffff2 lat 32",
                     bus.muldivresp_msg_result, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int seen;
        bus.muldivresp_rdy   = 1'b1;
        bus.muldivreq_msg_fn = 3'd0;
        bus.muldivreq_msg_a  = 32'd9;
        bus.muldivreq_msg_b  = 32'd9;
        bus.muldivreq_val    = 1'b1;
        @(posedge clk); #1;
        bus.muldivreq_val = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.muldivreq_rdy !== 1'b1 || bus.muldivresp_val !== 1'b0 ||
            bus.muldivresp_msg_result !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got req_rdy=%b resp_val=%b res=%h want 1/0/0",
                     bus.muldivreq_rdy, bus.muldivresp_val, bus.muldivresp_msg_result);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.muldivresp_val === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_resp: got %0d valid cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_unsigned();
        test_divzero();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
